hptdc_readout_ctrl: RTL
=======================

HPTDC_READOUT_CTRL -- requirements
Module: hptdc_readout_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000: the number of WAIT cycles without data_ready before the event is aborted.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256: the number of measurement words accepted per event.
REQ-003 The block SHALL have a single clock: clk  input  1  rising-edge clock.
REQ-004 The block SHALL have an asynchronous active-low reset: rst  input  1  reset.
REQ-005 The block SHALL have these ports:
- start  input  1  readout request pulse.
- hptdc_data_ready  input  1  TDC has a word.
- hptdc_data  input  32  TDC word.
- fifo_full  input  1  downstream backpressure.
- hptdc_trigger  output  1  trigger to TDC.
- hptdc_get_data  output  1  word acknowledge to TDC.
- fifo_wr_en  output  1  push strobe.
- fifo_wr_data  output  32  pushed word.
- busy  output  1  event in progress.
- event_done  output  1  end-of-event pulse.
- word_count  output  9  measurement words pushed this event.
- timeout_err  output  1  event ended by timeout.
- overflow_err  output  1  MAX_WORDS exceeded.

Function
REQ-006 The FSM SHALL have states IDLE, TRIG, WAIT, GET, PUSH and DONE, all registered; all outputs SHALL be registered or decoded from state only.
REQ-007 In IDLE with start=1, the FSM SHALL go to TRIG; start SHALL be ignored in every other state.
REQ-008 TRIG SHALL last one cycle, with hptdc_trigger=1, word_count, timer and error flags cleared, and busy=1; TRIG SHALL then go to WAIT. hptdc_trigger SHALL be asserted in the cycle after start is sampled.
REQ-009 In WAIT with hptdc_data_ready=1 and fifo_full=0, the FSM SHALL go to GET.
REQ-010 In WAIT with fifo_full=1, the FSM SHALL hold and the timer SHALL be frozen.
REQ-011 In WAIT otherwise, the timer SHALL increment; on reaching TIMEOUT_CYCLES the FSM SHALL set timeout_err and go to DONE.
REQ-012 GET SHALL last one cycle, with hptdc_get_data=1 and hptdc_data latched into the holding register at the end of the cycle; GET SHALL then go to PUSH.
REQ-013 PUSH SHALL last one cycle. Word type is holding[31:28]:
- 4'b010x: pushed if word_count < MAX_WORDS, then word_count increments; otherwise not pushed and overflow_err=1. Next state WAIT.
- 4'b0011 (trailer): pushed, not counted. Next state DONE.
- Other types: handled per REQ-021. Next state WAIT.
REQ-014 fifo_wr_en SHALL be high only in PUSH for a pushed word, with fifo_wr_data = holding register; it SHALL be asserted at most one cycle per TDC word.
REQ-015 The timer SHALL clear to 0 on every GET.
REQ-016 DONE SHALL last one cycle, with event_done=1 and busy=1; DONE SHALL then go to IDLE.
REQ-017 word_count, timeout_err and overflow_err SHALL hold their values in IDLE until the next TRIG.
REQ-018 word_count SHALL saturate at MAX_WORDS and SHALL never wrap.
REQ-019 busy SHALL be 1 in every state except IDLE.

Reset
REQ-020 When rst=0, the block SHALL immediately enter IDLE and drive every output to 0, including fifo_wr_data, word_count and all flags, as well as the timer and holding register. This SHALL hold mid-event, aborting the event with no event_done. The first start SHALL be honoured on the first clock edge after rst deasserts.

Configuration
REQ-021 The macro HPTDC_TYPE_FILTER_EN SHALL control word-type filtering. When defined, words of type other than 010x or 0011 SHALL be dropped in PUSH, with fifo_wr_en=0 and the timer still cleared. When undefined, all non-trailer, non-measurement words SHALL be pushed uncounted and SHALL not be limited by MAX_WORDS.

Verification
REQ-022 Scenario: start pulse; TDC returns 3 words 0x4000_0001, 0x5000_0002, 0x3000_0003 -> one trigger pulse at cycle 1; 3 get_data pulses; pushes in order; word_count=2; event_done once; errors 0.
REQ-023 Scenario: start with no data_ready -> timeout_err=1 and event_done exactly TIMEOUT_CYCLES+2 cycles after start; no fifo_wr_en.
REQ-024 Scenario: fifo_full held 50 cycles while data_ready=1 in WAIT -> no get_data and no timeout; first get_data within 1 cycle of fifo_full=0.
REQ-025 Scenario: MAX_WORDS=4; 6 words 0x4xxx_xxxx then trailer -> 4 measurement pushes plus trailer; word_count=4; overflow_err=1.
REQ-026 Scenario: word 0x6000_00FF mid-event -> dropped with filter defined, pushed with it undefined; word_count unchanged in both cases.
REQ-027 Scenario: rst=0 asserted in PUSH -> same-cycle outputs 0; no event_done; the next start runs a clean event.

Source files
------------

// File: rtl/hptdc_readout_ctrl.sv
// hptdc_readout_ctrl
//   Event readout sequencer for an HPTDC: triggers the TDC, acknowledges each
//   data word, forwards words to a downstream FIFO and reports per-event word
//   count and timeout/overflow status.
//   Build option: define HPTDC_TYPE_FILTER_EN to drop words whose type is
//   neither measurement (010x) nor trailer (0011); otherwise such words are
//   forwarded uncounted.
//   Reset: rst is asynchronous and active-low.
module hptdc_readout_ctrl #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_WORDS      = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        hptdc_data_ready,
   input  logic [31:0] hptdc_data,
   input  logic        fifo_full,
   output logic        hptdc_trigger,
   output logic        hptdc_get_data,
   output logic        fifo_wr_en,
   output logic [31:0] fifo_wr_data,
   output logic        busy,
   output logic        event_done,
   output logic [8:0]  word_count,
   output logic        timeout_err,
   output logic        overflow_err
);

   // timer counts 0..TIMEOUT_CYCLES-1; the last value marks the final WAIT cycle
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [9:0]    MAX_W      = 10'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT,
      GET,
      PUSH,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   timer;
   logic [31:0]     holding;
   logic            push_q;
   logic            meas_q;
   logic            trailer_q;

   logic [3:0]      in_type;
   logic            in_meas;
   logic            in_trailer;
   logic            in_push;
   logic            cnt_ok;
   logic            timer_last;

   assign in_type    = hptdc_data[31:28];
   assign in_meas    = (in_type[3:1] == 3'b010);
   assign in_trailer = (in_type == 4'b0011);
   assign cnt_ok     = ({1'b0, word_count} < MAX_W);
   assign timer_last = (timer == TIMER_LAST);

   // Push decision is made while the word is captured in GET, so PUSH only
   // decodes registered state and fifo_wr_en stays glitch-free.
   always_comb begin
      in_push = 1'b0;
      if (in_meas) begin
         in_push = cnt_ok;
      end else if (in_trailer) begin
         in_push = 1'b1;
      end else begin
`ifdef HPTDC_TYPE_FILTER_EN
         in_push = 1'b0;
`else
         in_push = 1'b1;
`endif
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      state_nxt      = state;
      hptdc_trigger  = 1'b0;
      hptdc_get_data = 1'b0;
      fifo_wr_en     = 1'b0;
      event_done     = 1'b0;
      busy           = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = TRIG;
         end
         TRIG: begin
            hptdc_trigger = 1'b1;
            state_nxt     = WAIT;
         end
         WAIT: begin
            if (!fifo_full) begin
               if (hptdc_data_ready)  state_nxt = GET;
               else if (timer_last)   state_nxt = DONE;
            end
         end
         GET: begin
            hptdc_get_data = 1'b1;
            state_nxt      = PUSH;
         end
         PUSH: begin
            fifo_wr_en = push_q;
            state_nxt  = trailer_q ? DONE : WAIT;
         end
         DONE: begin
            event_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   assign fifo_wr_data = holding;

   // Datapath: timer, holding register, word count and error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer        <= '0;
         holding      <= '0;
         push_q       <= 1'b0;
         meas_q       <= 1'b0;
         trailer_q    <= 1'b0;
         word_count   <= '0;
         timeout_err  <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         case (state)
            TRIG: begin
               timer        <= '0;
               word_count   <= '0;
               timeout_err  <= 1'b0;
               overflow_err <= 1'b0;
            end
            WAIT: begin
               if (!fifo_full && !hptdc_data_ready) begin
                  if (timer_last) timeout_err <= 1'b1;
                  else            timer       <= timer + 1'b1;
               end
            end
            GET: begin
               holding   <= hptdc_data;
               timer     <= '0;
               push_q    <= in_push;
               meas_q    <= in_meas;
               trailer_q <= in_trailer;
            end
            PUSH: begin
               if (meas_q) begin
                  if (push_q) word_count   <= word_count + 9'd1;
                  else        overflow_err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
